idu_pipe: RTL

- Registered, handshaked RV32I/RV32M decode stage for the NPC core. Sits between IFU and EXU.
- Decodes one instruction per cycle into a control bundle and holds it in an output register with valid/ready.
- A register scoreboard stalls issue on RAW/WAW hazards until writeback clears them.

---
 rtl/idu_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/idu_pipe.sv
// ============================================================================
// Module   : idu_pipe
// Purpose  : Registered RV32I/M decode stage with valid/ready and a register
//            scoreboard that interlocks issue on RAW/WAW hazards.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module idu_pipe #(
  parameter int XLEN          = 32,
  parameter int EN_RV32M      = 1,
  parameter int EN_SCOREBOARD = 1,
  parameter int ALU_OP_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [XLEN-1:0]     out_imm,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic                out_r_wen,
  output logic                out_mem_ren,
  output logic                out_mem_wen,
  output logic [1:0]          out_mem_size,
  output logic                out_sext,
  output logic [ALU_OP_W-1:0] out_alu_opcode,
  output logic [3:0]          out_muldiv_op,
  output logic [1:0]          out_npc_sel,
  output logic                out_illegal,
  output logic                out_halt,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  input  logic                flush
);

  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] c_OPC_MISC   = 7'b0001111;
  localparam logic [6:0] c_F7_ZERO    = 7'b0000000;
  localparam logic [6:0] c_F7_ALT     = 7'b0100000;
  localparam logic [6:0] c_F7_MULDIV  = 7'b0000001;
  localparam logic [31:0] c_ECALL     = 32'h0000_0073;
  localparam logic [31:0] c_EBREAK    = 32'h0010_0073;
  localparam logic [31:0] c_MRET      = 32'h3020_0073;

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  logic            w_r_wen;
  logic            w_mem_ren;
  logic            w_mem_wen;
  logic [1:0]      w_mem_size;
  logic            w_sext;
  logic [7:0]      w_alu;
  logic [ALU_OP_W-1:0] w_alu_full;
  logic [3:0]      w_muldiv;
  logic [1:0]      w_npc_sel;
  logic            w_halt;
  logic            w_uses_rs1;
  logic            w_uses_rs2;

  assign w_opc = in_inst[6:0];
  assign w_f3  = in_inst[14:12];
  assign w_f7  = in_inst[31:25];
  assign w_rd  = in_inst[11:7];
  assign w_rs2 = in_inst[24:20];

  always_comb begin
    w_illegal  = 1'b0;
    w_r_wen    = 1'b0;
    w_mem_ren  = 1'b0;
    w_mem_wen  = 1'b0;
    w_mem_size = 2'd0;
    w_sext     = 1'b0;
    w_alu      = 8'h00;
    w_muldiv   = 4'h0;
    w_npc_sel  = 2'b00;
    w_halt     = 1'b0;
    w_imm32    = 32'h0;
    w_uses_rs1 = 1'b1;
    w_uses_rs2 = 1'b0;
    w_rs1      = in_inst[19:15];
    case (w_opc)
      c_OPC_LUI: begin
        w_imm32    = {in_inst[31:12], 12'h000};
        w_r_wen    = 1'b1;
        w_uses_rs1 = 1'b0;
        w_rs1      = 5'd0;
      end
      c_OPC_AUIPC: begin
        w_imm32    = {in_inst[31:12], 12'h000};
        w_r_wen    = 1'b1;
        w_uses_rs1 = 1'b0;
      end
      c_OPC_JAL: begin
        w_imm32    = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                      in_inst[20], in_inst[30:21], 1'b0};
        w_r_wen    = 1'b1;
        w_npc_sel  = 2'b01;
        w_uses_rs1 = 1'b0;
      end
      c_OPC_JALR: begin
        w_imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        w_r_wen   = 1'b1;
        w_npc_sel = 2'b10;
        w_illegal = (w_f3 != 3'b000);
      end
      c_OPC_BRANCH: begin
        w_imm32    = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                      in_inst[30:25], in_inst[11:8], 1'b0};
        w_uses_rs2 = 1'b1;
        w_npc_sel  = 2'b11;
        case (w_f3)
          3'b000:  w_alu = 8'h03;
          3'b001:  w_alu = 8'h05;
          3'b100:  w_alu = 8'h21;
          3'b101:  w_alu = 8'h41;
          3'b110:  w_alu = 8'h09;
          3'b111:  w_alu = 8'h11;
          default: w_illegal = 1'b1;
        endcase
      end
      c_OPC_LOAD: begin
        w_imm32    = {{20{in_inst[31]}}, in_inst[31:20]};
        w_r_wen    = 1'b1;
        w_mem_ren  = 1'b1;
        w_mem_size = w_f3[1:0];
        w_sext     = (w_f3 == 3'b000) || (w_f3 == 3'b001);
        w_illegal  = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      c_OPC_STORE: begin
        w_imm32    = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        w_mem_wen  = 1'b1;
        w_uses_rs2 = 1'b1;
        w_mem_size = w_f3[1:0];
        w_illegal  = (w_f3 > 3'b010);
      end
      c_OPC_OPIMM: begin
        w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        w_r_wen = 1'b1;
        case (w_f3)
          3'b000: w_alu = 8'h00;
          3'b010: w_alu = 8'h21;
          3'b011: w_alu = 8'h09;
          3'b100: w_alu = 8'h02;
          3'b110: w_alu = 8'h04;
          3'b111: w_alu = 8'h08;
          3'b001: begin
            w_alu     = 8'h10;
            w_illegal = (w_f7 != c_F7_ZERO);
          end
          default: begin
            w_alu     = (w_f7 == c_F7_ALT) ? 8'h40 : 8'h20;
            w_illegal = (w_f7 != c_F7_ZERO) && (w_f7 != c_F7_ALT);
          end
        endcase
      end
      c_OPC_OP: begin
        w_r_wen    = 1'b1;
        w_uses_rs2 = 1'b1;
        if (w_f7 == c_F7_ZERO) begin
          case (w_f3)
            3'b000:  w_alu = 8'h00;
            3'b001:  w_alu = 8'h10;
            3'b010:  w_alu = 8'h21;
            3'b011:  w_alu = 8'h09;
            3'b100:  w_alu = 8'h02;
            3'b101:  w_alu = 8'h20;
            3'b110:  w_alu = 8'h04;
            default: w_alu = 8'h08;
          endcase
        end else if (w_f7 == c_F7_ALT && w_f3 == 3'b000) begin
          w_alu = 8'h01;
        end else if (w_f7 == c_F7_ALT && w_f3 == 3'b101) begin
          w_alu = 8'h40;
        end else if (w_f7 == c_F7_MULDIV && EN_RV32M != 0) begin
          w_muldiv = {1'b1, w_f3};
        end else begin
          w_illegal = 1'b1;
        end
      end
      c_OPC_SYSTEM: begin
        w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        if (w_f3 == 3'b000) begin
          // Only the three exact privileged encodings are accepted.
          if (in_inst == c_ECALL || in_inst == c_EBREAK) w_halt = 1'b1;
          else if (in_inst != c_MRET)                     w_illegal = 1'b1;
        end else if (w_f3 == 3'b100) begin
          w_illegal = 1'b1;
        end else begin
          w_r_wen = 1'b1;
          case (w_f3[1:0])
            2'b10:   w_alu = 8'h04;
            2'b11:   w_alu = 8'h80;
            default: w_alu = 8'h00;
          endcase
        end
      end
      c_OPC_MISC:  w_illegal = (w_f3[2:1] != 2'b00);
      default:     w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_r_wen   = 1'b0;
      w_mem_ren = 1'b0;
      w_mem_wen = 1'b0;
      w_halt    = 1'b0;
      w_npc_sel = 2'b00;
      w_muldiv  = 4'h0;
    end
    if (w_rd == 5'd0) w_r_wen = 1'b0;
  end

  assign w_imm = XLEN'($signed(w_imm32));

  always_comb begin
    w_alu_full      = '0;
    w_alu_full[7:0] = w_alu;
  end

  // Scoreboard: a writeback in flight this cycle already counts as cleared.
  logic [31:0] r_busy;
  logic [31:0] w_wb_mask;
  logic [31:0] w_busy_eff;
  logic        w_hazard;
  logic        w_accept;

  always_comb begin
    w_wb_mask = '0;
    if (wb_valid) w_wb_mask[wb_rd] = 1'b1;
  end

  assign w_busy_eff = r_busy & ~w_wb_mask;
  assign w_hazard   = (w_uses_rs1 & w_busy_eff[w_rs1]) |
                      (w_uses_rs2 & w_busy_eff[w_rs2]) |
                      (w_r_wen    & w_busy_eff[w_rd]);
  assign in_ready   = !rst && !flush && (!out_valid || out_ready) && !w_hazard;
  assign w_accept   = in_valid && in_ready;

  generate
    if (EN_SCOREBOARD != 0) begin : g_sb
      logic [31:0] w_busy_nxt;
      always_comb begin
        w_busy_nxt = r_busy & ~w_wb_mask;
        if (flush && out_valid && out_r_wen) w_busy_nxt[out_rd] = 1'b0;
        if (w_accept && w_r_wen)             w_busy_nxt[w_rd]   = 1'b1;
        w_busy_nxt[0] = 1'b0;
      end
      always_ff @(posedge clk) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
      end
    end else begin : g_nosb
      assign r_busy = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_imm        <= '0;
      out_rs1        <= '0;
      out_rs2        <= '0;
      out_rd         <= '0;
      out_r_wen      <= 1'b0;
      out_mem_ren    <= 1'b0;
      out_mem_wen    <= 1'b0;
      out_mem_size   <= '0;
      out_sext       <= 1'b0;
      out_alu_opcode <= '0;
      out_muldiv_op  <= '0;
      out_npc_sel    <= '0;
      out_illegal    <= 1'b0;
      out_halt       <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_accept) begin
      out_valid      <= 1'b1;
      out_pc         <= in_pc;
      out_imm        <= (w_opc == c_OPC_OP) ? '0 : w_imm;
      out_rs1        <= w_rs1;
      out_rs2        <= w_rs2;
      out_rd         <= w_rd;
      out_r_wen      <= w_r_wen;
      out_mem_ren    <= w_mem_ren;
      out_mem_wen    <= w_mem_wen;
      out_mem_size   <= w_mem_size;
      out_sext       <= w_sext;
      out_alu_opcode <= w_alu_full;
      out_muldiv_op  <= w_muldiv;
      out_npc_sel    <= w_npc_sel;
      out_illegal    <= w_illegal;
      out_halt       <= w_halt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire
